// File: rtl/trap_ctrl.sv
// Trap sequencer at the commit point: latches the winning trap or MRET, then
// runs a CSR-update cycle followed by a flush/redirect cycle.
module trap_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] badaddr_i,
    input  logic        exc_iaddr_mis,
    input  logic        exc_illegal,
    input  logic        exc_ebreak,
    input  logic        exc_ld_mis,
    input  logic        exc_st_mis,
    input  logic        exc_ecall,
    input  logic        mret_i,
    input  logic        ext_irq,
    input  logic        tmr_irq,
    input  logic [31:0] mstatus,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc_r,
    output logic        exception_unit_flag,
    output logic [31:0] mcause_w,
    output logic [31:0] mtval_w,
    output logic [31:0] mepc_w,
    output logic        mret,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAP  = 2'd1,
        RET   = 2'd2,
        REDIR = 2'd3
    } state_t;

    state_t state;

    logic ext_s1, ext_s2, tmr_s1, tmr_s2;
    logic ext_pend, tmr_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_s1 <= 1'b0;
            ext_s2 <= 1'b0;
            tmr_s1 <= 1'b0;
            tmr_s2 <= 1'b0;
        end else begin
            ext_s1 <= ext_irq;
            ext_s2 <= ext_s1;
            tmr_s1 <= tmr_irq;
            tmr_s2 <= tmr_s1;
        end
    end

    assign ext_pend = ext_s2 & mstatus[3];
    assign tmr_pend = tmr_s2 & mstatus[3];

    logic        sel_trap, sel_ret;
    logic [31:0] sel_cause, sel_tval;

    // Interrupts outrank exceptions; exceptions outrank MRET.
    always_comb begin
        sel_trap  = 1'b1;
        sel_ret   = 1'b0;
        sel_cause = 32'd0;
        sel_tval  = 32'd0;
        if (ext_pend) begin
            sel_cause = 32'h8000_000B;
        end else if (tmr_pend) begin
            sel_cause = 32'h8000_0007;
        end else if (exc_iaddr_mis) begin
            sel_cause = 32'd0;
            sel_tval  = badaddr_i;
        end else if (exc_illegal) begin
            sel_cause = 32'd2;
            sel_tval  = inst_i;
        end else if (exc_ebreak) begin
            sel_cause = 32'd3;
            sel_tval  = pc_i;
        end else if (exc_ld_mis) begin
            sel_cause = 32'd4;
            sel_tval  = badaddr_i;
        end else if (exc_st_mis) begin
            sel_cause = 32'd6;
            sel_tval  = badaddr_i;
        end else if (exc_ecall) begin
            sel_cause = 32'd11;
        end else begin
            sel_trap = 1'b0;
            sel_ret  = mret_i;
        end
    end

    logic [31:0] trap_base, trap_target;

    assign trap_base = {mtvec[31:2], 2'b00};

    // Vectored mode only offsets interrupts; synchronous exceptions use the base.
    always_comb begin
        trap_target = trap_base;
        if (mtvec[1:0] == 2'b01 && mcause_w[31])
            trap_target = trap_base + {25'd0, mcause_w[4:0], 2'b00};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            exception_unit_flag <= 1'b0;
            mret                <= 1'b0;
            redirect_valid      <= 1'b0;
            redirect_pc         <= RESET_PC;
            flush               <= 1'b0;
            busy                <= 1'b0;
            mcause_w            <= 32'd0;
            mtval_w             <= 32'd0;
            mepc_w              <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && sel_trap) begin
                        state               <= TRAP;
                        mcause_w            <= sel_cause;
                        mtval_w             <= sel_tval;
                        mepc_w              <= pc_i;
                        exception_unit_flag <= 1'b1;
                        busy                <= 1'b1;
                        flush               <= 1'b1;
                    end else if (valid_i && sel_ret) begin
                        state <= RET;
                        mret  <= 1'b1;
                        busy  <= 1'b1;
                        flush <= 1'b1;
                    end
                end
                TRAP: begin
                    state               <= REDIR;
                    exception_unit_flag <= 1'b0;
                    redirect_valid      <= 1'b1;
                    redirect_pc         <= trap_target;
                end
                RET: begin
                    state          <= REDIR;
                    mret           <= 1'b0;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= mepc_r & 32'hFFFF_FFFC;
                end
                default: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                    redirect_pc    <= RESET_PC;
                    flush          <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

    logic unused_bits;
    assign unused_bits = ^{mstatus[31:4], mstatus[2:0]};

endmodule
